// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage LEGv8 pipeline.
// Handles load-use stalls, taken-branch flush windows, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       ID_READ_REG_A,
  input  logic [4:0]       ID_READ_REG_B,
  input  logic             ID_USES_REG_B,
  input  logic             EX_MEMREAD,
  input  logic [4:0]       EX_WRITE_REG,
  input  logic             MEM_BRANCH_TAKEN,
  output logic             PC_WRITE,
  output logic             IF_ID_WRITE,
  output logic             ID_EX_BUBBLE,
  output logic             IF_ID_FLUSH,
  output logic             EX_MEM_FLUSH,
  output logic [CNT_W-1:0] STALL_COUNT,
  output logic [CNT_W-1:0] FLUSH_COUNT
);

  localparam int unsigned FCNT_W = 4;
  localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic              lu, stall_inc, flush_inc;

  // X31 reads as zero and therefore can never carry a load result forward.
  always_comb begin
    lu = EX_MEMREAD && (EX_WRITE_REG != XZR) &&
         ((EX_WRITE_REG == ID_READ_REG_A) ||
          (ID_USES_REG_B && (EX_WRITE_REG == ID_READ_REG_B)));
  end

  always_comb begin
    state_nxt    = state;
    fcnt_nxt     = fcnt;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    PC_WRITE     = 1'b1;
    IF_ID_WRITE  = 1'b1;
    ID_EX_BUBBLE = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    EX_MEM_FLUSH = 1'b0;
    if (!RESET) begin
      state_nxt    = RUN;
      fcnt_nxt     = '0;
      PC_WRITE     = 1'b0;
      IF_ID_WRITE  = 1'b0;
      ID_EX_BUBBLE = 1'b1;
      IF_ID_FLUSH  = 1'b1;
      EX_MEM_FLUSH = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (MEM_BRANCH_TAKEN) begin
            ID_EX_BUBBLE = 1'b1;
            IF_ID_FLUSH  = 1'b1;
            EX_MEM_FLUSH = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              fcnt_nxt  = FLUSH_INIT;
            end
          end else if (lu) begin
            PC_WRITE     = 1'b0;
            IF_ID_WRITE  = 1'b0;
            ID_EX_BUBBLE = 1'b1;
            stall_inc    = 1'b1;
          end
        end
        FLUSH: begin
          ID_EX_BUBBLE = 1'b1;
          IF_ID_FLUSH  = 1'b1;
          EX_MEM_FLUSH = 1'b1;
          fcnt_nxt     = fcnt - FCNT_W'(1);
          if (fcnt <= FCNT_W'(1)) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= RUN;
      fcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign STALL_COUNT = stall_cnt;
  assign FLUSH_COUNT = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (3-cycle flush / 4-bit counters and
// 1-cycle flush / 8-bit counters) share stimulus and are checked against a reference model.
module tb_hazard_ctrl;

  localparam int FC0 = 3;
  localparam int W0  = 4;
  localparam int FC1 = 1;
  localparam int W1  = 8;

  logic       CLK;
  logic       RESET;
  logic [4:0] ID_READ_REG_A, ID_READ_REG_B, EX_WRITE_REG;
  logic       ID_USES_REG_B, EX_MEMREAD, MEM_BRANCH_TAKEN;

  logic          pc0, ifw0, bub0, iff0, emf0;
  logic [W0-1:0] sc0, fc0;
  logic          pc1, ifw1, bub1, iff1, emf1;
  logic [W1-1:0] sc1, fc1;

  hazard_ctrl #(.FLUSH_CYCLES(FC0), .CNT_W(W0)) u_dut0 (
    .CLK(CLK), .RESET(RESET),
    .ID_READ_REG_A(ID_READ_REG_A), .ID_READ_REG_B(ID_READ_REG_B),
    .ID_USES_REG_B(ID_USES_REG_B), .EX_MEMREAD(EX_MEMREAD),
    .EX_WRITE_REG(EX_WRITE_REG), .MEM_BRANCH_TAKEN(MEM_BRANCH_TAKEN),
    .PC_WRITE(pc0), .IF_ID_WRITE(ifw0), .ID_EX_BUBBLE(bub0),
    .IF_ID_FLUSH(iff0), .EX_MEM_FLUSH(emf0),
    .STALL_COUNT(sc0), .FLUSH_COUNT(fc0)
  );

  hazard_ctrl #(.FLUSH_CYCLES(FC1), .CNT_W(W1)) u_dut1 (
    .CLK(CLK), .RESET(RESET),
    .ID_READ_REG_A(ID_READ_REG_A), .ID_READ_REG_B(ID_READ_REG_B),
    .ID_USES_REG_B(ID_USES_REG_B), .EX_MEMREAD(EX_MEMREAD),
    .EX_WRITE_REG(EX_WRITE_REG), .MEM_BRANCH_TAKEN(MEM_BRANCH_TAKEN),
    .PC_WRITE(pc1), .IF_ID_WRITE(ifw1), .ID_EX_BUBBLE(bub1),
    .IF_ID_FLUSH(iff1), .EX_MEM_FLUSH(emf1),
    .STALL_COUNT(sc1), .FLUSH_COUNT(fc1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Flag order: {PC_WRITE, IF_ID_WRITE, ID_EX_BUBBLE, IF_ID_FLUSH, EX_MEM_FLUSH}
  typedef struct {
    logic [4:0] flags;
    int         stall;
    int         flush;
    string      tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: remaining forced-flush cycles and counter values.
  int flush_left[2] = '{0, 0};
  int stalls[2]     = '{0, 0};
  int flushes[2]    = '{0, 0};

  function automatic bit load_use(logic memrd, logic [4:0] wr, logic [4:0] a,
                                  logic [4:0] b, logic usesb);
    if (!memrd || wr == 5'd31) return 1'b0;
    return (wr == a) || (usesb && wr == b);
  endfunction

  task automatic model_step(input int i, input bit rst_n, input bit lu, input bit br,
                            input string tag, output exp_t e);
    int fcyc = (i == 0) ? FC0 : FC1;
    int cmax = (i == 0) ? (2 ** W0) - 1 : (2 ** W1) - 1;
    e.tag = tag;
    if (!rst_n) begin
      flush_left[i] = 0;
      stalls[i]     = 0;
      flushes[i]    = 0;
      e.flags       = 5'b00111;
    end else if (flush_left[i] > 0) begin
      e.flags       = 5'b11111;
      flush_left[i] = flush_left[i] - 1;
    end else if (br) begin
      e.flags       = 5'b11111;
      flush_left[i] = fcyc - 1;
    end else if (lu) begin
      e.flags = 5'b00100;
    end else begin
      e.flags = 5'b11000;
    end
    // Counters are observed before the edge that applies this cycle's increment.
    e.stall = stalls[i];
    e.flush = flushes[i];
    if (rst_n && e.flags == 5'b11111 && br && e.flags[2] && flush_left[i] == fcyc - 1
        && !(fcyc > 1 && flush_left[i] == 0 && 0)) begin
    end
  endtask

  // Applies counter increments after the expected values for this cycle were captured.
  task automatic model_count(input int i, input bit rst_n, input bit in_flush,
                             input bit lu, input bit br);
    int cmax = (i == 0) ? (2 ** W0) - 1 : (2 ** W1) - 1;
    if (!rst_n || in_flush) return;
    if (br) begin
      if (flushes[i] < cmax) flushes[i]++;
    end else if (lu) begin
      if (stalls[i] < cmax) stalls[i]++;
    end
  endtask

  task automatic drive(input bit rst_n, input logic [4:0] a, input logic [4:0] b,
                       input bit usesb, input bit memrd, input logic [4:0] wr,
                       input bit br, input string tag);
    exp_t e;
    bit   lu;
    bit   busy;
    @(negedge CLK);
    RESET            = rst_n;
    ID_READ_REG_A    = a;
    ID_READ_REG_B    = b;
    ID_USES_REG_B    = usesb;
    EX_MEMREAD       = memrd;
    EX_WRITE_REG     = wr;
    MEM_BRANCH_TAKEN = br;
    lu = load_use(memrd, wr, a, b, usesb);
    for (int i = 0; i < 2; i++) begin
      busy = rst_n && (flush_left[i] > 0);
      model_step(i, rst_n, lu, br, tag, e);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
      model_count(i, rst_n, busy, lu, br);
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a result late in the low phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check({"d0 flags ", e.tag}, 32'({pc0, ifw0, bub0, iff0, emf0}), 32'(e.flags));
        check({"d0 stall_count ", e.tag}, 32'(sc0), e.stall);
        check({"d0 flush_count ", e.tag}, 32'(fc0), e.flush);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check({"d1 flags ", e.tag}, 32'({pc1, ifw1, bub1, iff1, emf1}), 32'(e.flags));
        check({"d1 stall_count ", e.tag}, 32'(sc1), e.stall);
        check({"d1 flush_count ", e.tag}, 32'(fc1), e.flush);
      end
    end
  end

  initial begin
    logic [4:0] regs[4];
    RESET = 1'b0;
    ID_READ_REG_A = '0; ID_READ_REG_B = '0; ID_USES_REG_B = 1'b0;
    EX_MEMREAD = 1'b0; EX_WRITE_REG = '0; MEM_BRANCH_TAKEN = 1'b0;

    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, "reset");
    drive(1, 1, 2, 1, 0, 3, 0, "idle");

    // Load-use on register A, then the bubble reaches EX.
    drive(1, 5, 0, 0, 1, 5, 0, "lu_a");
    drive(1, 5, 0, 0, 0, 5, 0, "after_lu_a");

    // Register B gating and XZR.
    drive(1, 1, 7, 0, 1, 7, 0, "b_unused");
    drive(1, 31, 2, 0, 1, 31, 0, "xzr");
    drive(1, 1, 7, 1, 1, 7, 0, "lu_b");
    drive(1, 1, 7, 1, 0, 7, 0, "after_lu_b");

    // Taken branch alone.
    drive(1, 0, 0, 0, 0, 0, 1, "branch");
    repeat (3) drive(1, 0, 0, 0, 0, 0, 0, "post_branch");

    // Branch coinciding with a load-use held for three cycles.
    drive(1, 4, 0, 0, 1, 4, 1, "br_lu");
    repeat (2) drive(1, 4, 0, 0, 1, 4, 0, "br_lu_hold");
    drive(1, 4, 0, 0, 0, 4, 0, "br_lu_done");

    // Branch held high during the flush window must not restart or recount it.
    repeat (3) drive(1, 0, 0, 0, 0, 0, 1, "br_held");
    drive(1, 0, 0, 0, 0, 0, 0, "br_held_done");

    // Saturate the stall counter of the 4-bit instance.
    repeat (18) drive(1, 9, 0, 0, 1, 9, 0, "sat");
    drive(1, 9, 0, 0, 0, 9, 0, "sat_done");

    // Reset in the middle of a flush window.
    drive(1, 0, 0, 0, 0, 0, 1, "br_pre_rst");
    drive(0, 0, 0, 0, 0, 0, 0, "mid_flush_rst");
    drive(1, 0, 0, 0, 0, 0, 0, "post_rst");
    drive(1, 6, 0, 0, 1, 6, 0, "post_rst_lu");

    // Randomized traffic with a small register pool to make hazards frequent.
    regs = '{5'd3, 5'd7, 5'd31, 5'd12};
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 99) != 0),
            regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
            regs[$urandom_range(0, 3)], ($urandom_range(0, 7) == 0), "rand");
    end

    drive(1, 0, 0, 0, 0, 0, 0, "tail");
    for (int k = 0; k < 10 && (q0.size() > 0 || q1.size() > 0); k++) @(negedge CLK);
    #5;
    if (q0.size() > 0 || q1.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and pipeline-control unit for the 5-stage ARM (LEGv8) pipeline.
- Decides what the ID stage writes into the ID/EX pipeline register each cycle: the decoded instruction, a bubble, or a flush.
- Detects load-use hazards (ID source register vs. EX-stage load destination) and freezes PC and IF/ID while injecting one bubble.
- Flushes IF/ID, ID/EX and EX/MEM for FLUSH_CYCLES cycles after a taken branch resolves in MEM, and keeps saturating stall/flush performance counters.

Parameters:
- FLUSH_CYCLES, 1, consecutive cycles flush outputs stay asserted after a taken branch (1..15).
- CNT_W, 32, width of each performance counter.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset
- ID_READ_REG_A  in  5  Rn of the instruction in ID
- ID_READ_REG_B  in  5  Rm/Rt of the instruction in ID (after reg2loc mux)
- ID_USES_REG_B  in  1  instruction in ID actually reads register B
- EX_MEMREAD  in  1  memRead of the instruction currently in EX
- EX_WRITE_REG  in  5  destination register of the instruction in EX
- MEM_BRANCH_TAKEN  in  1  branch in MEM stage is taken (branch & zero, or unconditional)
- PC_WRITE  out  1  1 = PC may update
- IF_ID_WRITE  out  1  1 = IF/ID register may load
- ID_EX_BUBBLE  out  1  1 = ID/EX loads all-zero control signals this edge
- IF_ID_FLUSH  out  1  1 = IF/ID loads a NOP
- EX_MEM_FLUSH  out  1  1 = EX/MEM loads zero control signals
- STALL_COUNT  out  CNT_W  load-use stall cycles taken
- FLUSH_COUNT  out  CNT_W  taken-branch flush events

Behaviour:
- FSM states: RUN, FLUSH. A 4-bit flush counter `fcnt` tracks the flush window.
- Reset (RESET=0, asynchronous):
  - state=RUN, fcnt=0, STALL_COUNT=0, FLUSH_COUNT=0.
  - While RESET=0, combinational outputs are forced to PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1, IF_ID_FLUSH=1, EX_MEM_FLUSH=1.
- Load-use hazard, `lu`: EX_MEMREAD=1 and EX_WRITE_REG≠31, and either
  - EX_WRITE_REG==ID_READ_REG_A, or
  - ID_USES_REG_B=1 and EX_WRITE_REG==ID_READ_REG_B.
  - X31 (XZR) never causes a hazard.
- Outputs are combinational from state and inputs, with zero-cycle latency:
  - RUN, MEM_BRANCH_TAKEN=1 (highest priority):
    - IF_ID_FLUSH=1, ID_EX_BUBBLE=1, EX_MEM_FLUSH=1, PC_WRITE=1 (the branch target loads), IF_ID_WRITE=1.
    - `lu` is ignored.
    - Next state: FLUSH with fcnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else stay in RUN.
    - FLUSH_COUNT increments.
  - RUN, `lu`=1, no branch:
    - PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1, flushes 0.
    - STALL_COUNT increments.
    - After this cycle the bubble sits in EX (EX_MEMREAD=0), so the stall is exactly one cycle per load-use pair.
  - RUN, otherwise: PC_WRITE=1, IF_ID_WRITE=1, all bubble/flush outputs 0.
  - FLUSH:
    - IF_ID_FLUSH=1, ID_EX_BUBBLE=1, EX_MEM_FLUSH=1, PC_WRITE=1, IF_ID_WRITE=1.
    - `lu` and MEM_BRANCH_TAKEN are ignored; no counter increments.
    - fcnt decrements each cycle; when fcnt==1, the next state is RUN.
- Counters saturate at all-ones and never wrap.
- Reset mid-FLUSH returns to RUN immediately; counters clear.
- Simultaneous `lu` and branch: the branch wins, no stall is counted, and the offending load is flushed along with everything else.

Test Plan:
- Reset: hold RESET=0 for 3 cycles, then release with no hazards → PC_WRITE=1, IF_ID_WRITE=1, all flush/bubble outputs 0, both counters 0.
- Load-use on A: EX_MEMREAD=1, EX_WRITE_REG=5, ID_READ_REG_A=5 for one cycle, then EX_MEMREAD=0 → exactly one cycle of PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1; STALL_COUNT=1.
- Reg B gating and XZR:
  - EX_WRITE_REG=7, ID_READ_REG_B=7, ID_USES_REG_B=0 → no stall.
  - EX_WRITE_REG=31, ID_READ_REG_A=31 → no stall.
  - ID_USES_REG_B=1, regs equal (7) → stall.
- Taken branch, FLUSH_CYCLES=1: MEM_BRANCH_TAKEN=1 for one cycle → all three flushes asserted that cycle only, PC_WRITE=1; FLUSH_COUNT=1.
- Branch plus load-use, FLUSH_CYCLES=3: branch and `lu` in the same cycle, `lu` held for 3 cycles → flushes high for 3 cycles, PC_WRITE=1 throughout, STALL_COUNT unchanged, FLUSH_COUNT +1.
- Saturation and mid-flush reset:
  - Force `lu` for 2^CNT_W+2 cycles with CNT_W=4 → STALL_COUNT holds 15.
  - Assert RESET during FLUSH → outputs take reset values immediately; after release, state is RUN.
